// File: rtl/csr_dec_pkg.sv
// Shared types, response tags and the target-index helper for the CSR address decoder.
// Holds no logic of its own.
package csr_dec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      UNMAP = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [31:0] UNMAP_TAG = 32'h5555_AAAA;
   localparam logic [31:0] TMO_TAG   = 32'hDEAD_BEEF;

   // Target index lives in the top sel_w bits of the address.
   function automatic int unsigned tgt_idx(input logic [31:0] addr,
                                           input int unsigned addr_w,
                                           input int unsigned sel_w);
      return (addr >> (addr_w - sel_w)) & ((32'd1 << sel_w) - 32'd1);
   endfunction

endpackage

// File: rtl/csr_rd_timer.sv
// Read wait counter: cleared when a read is accepted, counts while the decoder waits for an ack.
// expired is combinational and goes high in the cycle the count equals TMO_CYC.
module csr_rd_timer #(
   parameter int unsigned TMO_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic expired
);

   logic [15:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (start) begin
         count <= '0;
      end else if (run) begin
         count <= count + 16'd1;
      end
   end

   assign expired = run && (count == 16'(TMO_CYC));

endmodule

// File: rtl/csr_mm_decoder_n.sv
// CSR decoder/mux: registered request stage (strobes at T+1), posted writes, one outstanding read.
// Read response one cycle after the ack; reads issued while busy are dropped and counted.
module csr_mm_decoder_n
   import csr_dec_pkg::*;
#(
   parameter int unsigned NUM_TGT = 8,
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned TMO_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      iMM_WR_EN,
   input  logic                      iMM_RD_EN,
   input  logic [ADDR_W-1:0]         iMM_ADDR,
   input  logic [DATA_W-1:0]         iMM_WR_DATA,
   output logic [DATA_W-1:0]         oMM_RD_DATA,
   output logic                      oMM_RD_DATA_V,
   output logic                      oMM_BUSY,
   output logic [ADDR_W-1:0]         oTGT_ADDR,
   output logic [DATA_W-1:0]         oTGT_WR_DATA,
   output logic [NUM_TGT-1:0]        oTGT_WR_EN,
   output logic [NUM_TGT-1:0]        oTGT_RD_EN,
   input  logic [NUM_TGT*DATA_W-1:0] iTGT_RD_DATA,
   input  logic [NUM_TGT-1:0]        iTGT_RD_DATA_V,
   input  logic                      iERR_CLR,
   output logic                      oERR_STICKY,
   output logic [15:0]               oTMO_CNT,
   output logic [15:0]               oDROP_CNT
);

   state_t              state;
   int unsigned         req_idx;
   logic                req_mapped;
   logic [NUM_TGT-1:0]  req_onehot;
   logic                rd_ok;
   logic                drop_evt;
   logic                tmo_evt;
   logic                expired;
   logic [NUM_TGT-1:0]  lat_onehot;
   logic [ADDR_W-1:0]   lat_addr;
   logic                ack_hit;
   logic [DATA_W-1:0]   ack_data;
   logic [DATA_W-1:0]   err_word;

   always_comb begin
      req_idx    = tgt_idx(32'(iMM_ADDR), ADDR_W, SEL_W);
      req_mapped = (req_idx < NUM_TGT);
      req_onehot = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         req_onehot[i] = (req_idx == i);
      end
   end

   // RESP is the response cycle with busy already low, so a new read is accepted there too.
   assign rd_ok    = iMM_RD_EN && (state == IDLE || state == RESP);
   assign drop_evt = iMM_RD_EN && !rd_ok;

   // Only the latched target's ack counts; others are ignored.
   always_comb begin
      ack_hit  = |(iTGT_RD_DATA_V & lat_onehot);
      ack_data = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (lat_onehot[i]) begin
            ack_data = ack_data | iTGT_RD_DATA[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      err_word                    = '0;
      err_word[ADDR_W-1:0]        = lat_addr;
      err_word[DATA_W-1 -: 32]    = (state == UNMAP) ? UNMAP_TAG : TMO_TAG;
   end

   // Ack wins over expiry in the same cycle.
   assign tmo_evt = (state == WAIT) && !ack_hit && expired;

   csr_rd_timer #(
      .TMO_CYC (TMO_CYC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (rd_ok),
      .run     (state == WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         oMM_BUSY      <= 1'b0;
         oMM_RD_DATA_V <= 1'b0;
         oMM_RD_DATA   <= '0;
         oTGT_ADDR     <= '0;
         oTGT_WR_DATA  <= '0;
         oTGT_WR_EN    <= '0;
         oTGT_RD_EN    <= '0;
         lat_onehot    <= '0;
         lat_addr      <= '0;
      end else begin
         oTGT_ADDR     <= iMM_ADDR;
         oTGT_WR_DATA  <= iMM_WR_DATA;
         oTGT_WR_EN    <= iMM_WR_EN ? req_onehot : '0;
         oTGT_RD_EN    <= rd_ok ? req_onehot : '0;
         oMM_RD_DATA_V <= 1'b0;

         case (state)
            IDLE, RESP: begin
               if (rd_ok) begin
                  lat_onehot <= req_onehot;
                  lat_addr   <= iMM_ADDR;
                  oMM_BUSY   <= 1'b1;
                  state      <= req_mapped ? WAIT : UNMAP;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (ack_hit) begin
                  oMM_RD_DATA   <= ack_data;
                  oMM_RD_DATA_V <= 1'b1;
                  oMM_BUSY      <= 1'b0;
                  state         <= RESP;
               end else if (expired) begin
                  oMM_RD_DATA   <= err_word;
                  oMM_RD_DATA_V <= 1'b1;
                  oMM_BUSY      <= 1'b0;
                  state         <= RESP;
               end
            end
            UNMAP: begin
               oMM_RD_DATA   <= err_word;
               oMM_RD_DATA_V <= 1'b1;
               oMM_BUSY      <= 1'b0;
               state         <= RESP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oTMO_CNT    <= '0;
         oDROP_CNT   <= '0;
         oERR_STICKY <= 1'b0;
      end else if (iERR_CLR) begin
         oTMO_CNT    <= '0;
         oDROP_CNT   <= '0;
         oERR_STICKY <= 1'b0;
      end else begin
         if (tmo_evt && oTMO_CNT != 16'hFFFF) begin
            oTMO_CNT <= oTMO_CNT + 16'd1;
         end
         if (drop_evt && oDROP_CNT != 16'hFFFF) begin
            oDROP_CNT <= oDROP_CNT + 16'd1;
         end
         if (tmo_evt || drop_evt) begin
            oERR_STICKY <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_csr_mm_decoder_n.sv
// Bench for csr_mm_decoder_n (6 targets, timeout 4): directed vector table, reset corner case,
// then random traffic against a timestamp-style transaction model.
module tb_csr_mm_decoder_n;

   localparam int NT  = 6;
   localparam int AW  = 14;
   localparam int DW  = 64;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mm_wr, mm_rd, err_clr;
   logic [AW-1:0] mm_addr;
   logic [DW-1:0] mm_wdata;
   logic [DW-1:0] rd_data;
   logic          rd_v, busy;
   logic [AW-1:0] tgt_addr;
   logic [DW-1:0] tgt_wdata;
   logic [NT-1:0] tgt_wr_en, tgt_rd_en, tgt_v;
   logic [NT*DW-1:0] tgt_rd_data;
   logic [DW-1:0] slot [NT];
   logic          sticky;
   logic [15:0]   tmo_cnt, drop_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   bit            m_pend, m_unmap, m_v, m_sticky, m_busy;
   int            m_tgt, m_age, m_tmo, m_drop;
   logic [AW-1:0] m_addr, m_taddr;
   logic [DW-1:0] m_rdata, m_wdata;
   logic [NT-1:0] m_wr_en, m_rd_en;

   typedef struct {
      bit            wr, rd, clr;
      logic [AW-1:0] addr;
      logic [NT-1:0] ack;
      logic [DW-1:0] dat;
      logic [NT-1:0] e_wr, e_rd;
      bit            e_v;
      logic [DW-1:0] e_data;
      bit            e_busy;
      int            e_tmo, e_drop;
      bit            e_sticky;
   } vec_t;

   vec_t tv [29];

   always #5 clk = ~clk;

   always_comb begin
      tgt_rd_data = '0;
      for (int i = 0; i < NT; i++) tgt_rd_data[i*DW +: DW] = slot[i];
   end

   csr_mm_decoder_n #(
      .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW), .SEL_W(4), .TMO_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .iMM_WR_EN(mm_wr), .iMM_RD_EN(mm_rd), .iMM_ADDR(mm_addr), .iMM_WR_DATA(mm_wdata),
      .oMM_RD_DATA(rd_data), .oMM_RD_DATA_V(rd_v), .oMM_BUSY(busy),
      .oTGT_ADDR(tgt_addr), .oTGT_WR_DATA(tgt_wdata), .oTGT_WR_EN(tgt_wr_en), .oTGT_RD_EN(tgt_rd_en),
      .iTGT_RD_DATA(tgt_rd_data), .iTGT_RD_DATA_V(tgt_v),
      .iERR_CLR(err_clr), .oERR_STICKY(sticky), .oTMO_CNT(tmo_cnt), .oDROP_CNT(drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input bit wr, input bit rd, input bit clr, input logic [AW-1:0] addr,
                         input logic [NT-1:0] ack, input logic [DW-1:0] dat);
      mm_wr = wr; mm_rd = rd; err_clr = clr; mm_addr = addr; mm_wdata = dat; tgt_v = ack;
      for (int i = 0; i < NT; i++) slot[i] = dat;
   endtask

   task automatic model_reset();
      m_pend = 0; m_unmap = 0; m_v = 0; m_sticky = 0; m_busy = 0;
      m_tgt = 0; m_age = 0; m_tmo = 0; m_drop = 0;
      m_addr = '0; m_taddr = '0; m_rdata = '0; m_wdata = '0; m_wr_en = '0; m_rd_en = '0;
   endtask

   // Predicts the outputs of the next cycle from the current inputs.
   task automatic model_step();
      int idx;
      bit busy_now, tmo_e, drop_e;
      idx      = int'(mm_addr[AW-1 -: 4]);
      busy_now = m_pend;
      tmo_e    = 0;
      drop_e   = 0;
      m_v      = 0;
      m_taddr  = mm_addr;
      m_wdata  = mm_wdata;
      m_wr_en  = (mm_wr && idx < NT) ? NT'(1 << idx) : '0;
      m_rd_en  = '0;
      if (m_pend) begin
         if (m_unmap) begin
            m_rdata = 64'h5555_AAAA_0000_0000 | 64'(m_addr);
            m_v = 1; m_pend = 0;
         end else if (tgt_v[m_tgt[2:0]]) begin
            m_rdata = slot[m_tgt];
            m_v = 1; m_pend = 0;
         end else if (m_age == TMO) begin
            m_rdata = 64'hDEAD_BEEF_0000_0000 | 64'(m_addr);
            m_v = 1; m_pend = 0; tmo_e = 1;
         end else begin
            m_age++;
         end
      end
      if (mm_rd) begin
         if (busy_now) begin
            drop_e = 1;
         end else begin
            m_pend = 1; m_age = 0; m_tgt = idx; m_unmap = (idx >= NT); m_addr = mm_addr;
            if (!m_unmap) m_rd_en = NT'(1 << idx);
         end
      end
      if (err_clr) begin
         m_tmo = 0; m_drop = 0; m_sticky = 0;
      end else begin
         if (tmo_e && m_tmo < 65535) m_tmo++;
         if (drop_e && m_drop < 65535) m_drop++;
         if (tmo_e || drop_e) m_sticky = 1;
      end
      m_busy = m_pend;
   endtask

   task automatic check_all();
      chk("rd_v",      64'(rd_v),      64'(m_v));
      chk("rd_data",   rd_data,        m_rdata);
      chk("busy",      64'(busy),      64'(m_busy));
      chk("wr_en",     64'(tgt_wr_en), 64'(m_wr_en));
      chk("rd_en",     64'(tgt_rd_en), 64'(m_rd_en));
      chk("tgt_addr",  64'(tgt_addr),  64'(m_taddr));
      chk("tgt_wdata", tgt_wdata,      m_wdata);
      chk("tmo_cnt",   64'(tmo_cnt),   64'(m_tmo));
      chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
      chk("sticky",    64'(sticky),    64'(m_sticky));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      // inputs / expected next-cycle outputs
      tv[0]  = '{1,0,0,14'h0805,6'h00,64'h1234, 6'h04,6'h00,0,64'h0,0,0,0,0};
      tv[1]  = '{0,1,0,14'h1410,6'h00,64'h0,    6'h00,6'h20,0,64'h0,1,0,0,0};
      tv[2]  = '{0,0,0,14'h0000,6'h00,64'h0,    6'h00,6'h00,0,64'h0,1,0,0,0};
      tv[3]  = tv[2];
      tv[4]  = tv[2];
      tv[5]  = '{0,0,0,14'h0000,6'h20,64'hCAFE, 6'h00,6'h00,1,64'hCAFE,0,0,0,0};
      tv[6]  = '{0,1,0,14'h3803,6'h00,64'h0,    6'h00,6'h00,0,64'h0,1,0,0,0};
      tv[7]  = '{0,0,0,14'h0000,6'h00,64'h0,    6'h00,6'h00,1,64'h5555_AAAA_0000_3803,0,0,0,0};
      tv[8]  = '{1,1,0,14'h0C00,6'h00,64'h77,   6'h08,6'h08,0,64'h0,1,0,0,0};
      tv[9]  = '{0,1,0,14'h0C00,6'h00,64'h0,    6'h00,6'h00,0,64'h0,1,0,1,1};
      tv[10] = '{0,0,0,14'h0000,6'h00,64'h0,    6'h00,6'h00,0,64'h0,1,0,1,1};
      tv[11] = tv[10];
      tv[12] = tv[10];
      tv[13] = '{0,0,0,14'h0000,6'h00,64'h0,    6'h00,6'h00,1,64'hDEAD_BEEF_0000_0C00,0,1,1,1};
      tv[14] = '{0,0,0,14'h0000,6'h00,64'h0,    6'h00,6'h00,0,64'h0,0,1,1,1};
      tv[15] = '{0,0,0,14'h0000,6'h08,64'h55,   6'h00,6'h00,0,64'h0,0,1,1,1};
      tv[16] = '{0,0,1,14'h0000,6'h00,64'h0,    6'h00,6'h00,0,64'h0,0,0,0,0};
      tv[17] = '{1,0,0,14'h1800,6'h00,64'h66,   6'h00,6'h00,0,64'h0,0,0,0,0};
      tv[18] = '{0,1,0,14'h0400,6'h00,64'h0,    6'h00,6'h02,0,64'h0,1,0,0,0};
      tv[19] = '{0,0,0,14'h0000,6'h04,64'h44,   6'h00,6'h00,0,64'h0,1,0,0,0};
      tv[20] = '{0,0,0,14'h0000,6'h06,64'hA1,   6'h00,6'h00,1,64'hA1,0,0,0,0};
      tv[21] = '{0,1,0,14'h0400,6'h00,64'h0,    6'h00,6'h02,0,64'h0,1,0,0,0};
      tv[22] = tv[2];
      tv[23] = tv[2];
      tv[24] = tv[2];
      tv[25] = tv[2];
      tv[26] = '{0,0,0,14'h0000,6'h02,64'hA5,   6'h00,6'h00,1,64'hA5,0,0,0,0};
      tv[27] = '{0,1,0,14'h0400,6'h00,64'h0,    6'h00,6'h02,0,64'h0,1,0,0,0};
      tv[28] = '{0,0,0,14'h0000,6'h02,64'h99,   6'h00,6'h00,1,64'h99,0,0,0,0};

      set_in(0, 0, 0, '0, '0, '0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_rd_v", 64'(rd_v), 64'h0);
      chk("reset_rd_data", rd_data, 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_strobes", 64'({tgt_wr_en, tgt_rd_en}), 64'h0);
      chk("reset_tgt_addr", 64'(tgt_addr), 64'h0);
      chk("reset_tgt_wdata", tgt_wdata, 64'h0);
      chk("reset_errs", 64'({sticky, tmo_cnt, drop_cnt}), 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 29; i++) begin
         set_in(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].addr, tv[i].ack, tv[i].dat);
         tick();
         chk($sformatf("tv%0d_wr_en", i), 64'(tgt_wr_en), 64'(tv[i].e_wr));
         chk($sformatf("tv%0d_rd_en", i), 64'(tgt_rd_en), 64'(tv[i].e_rd));
         chk($sformatf("tv%0d_rd_v", i), 64'(rd_v), 64'(tv[i].e_v));
         if (tv[i].e_v) chk($sformatf("tv%0d_rd_data", i), rd_data, tv[i].e_data);
         chk($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].e_busy));
         chk($sformatf("tv%0d_tmo", i), 64'(tmo_cnt), 64'(tv[i].e_tmo));
         chk($sformatf("tv%0d_drop", i), 64'(drop_cnt), 64'(tv[i].e_drop));
         chk($sformatf("tv%0d_sticky", i), 64'(sticky), 64'(tv[i].e_sticky));
      end

      // Reset while a read waits for its ack, then the stale ack arrives.
      set_in(0, 1, 0, 14'h0400, '0, '0);
      tick();
      set_in(0, 0, 0, '0, '0, '0);
      tick();
      chk("midrst_busy_before", 64'(busy), 64'h1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'h0);
      chk("midrst_rd_v", 64'(rd_v), 64'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_in(0, 0, 0, '0, 6'h02, 64'hBAD);
      tick();
      chk("midrst_stale_ack", 64'(rd_v), 64'h0);
      set_in(0, 1, 0, 14'h0400, '0, '0);
      tick();
      set_in(0, 0, 0, '0, 6'h02, 64'h1111);
      tick();
      chk("midrst_next_v", 64'(rd_v), 64'h1);
      chk("midrst_next_data", rd_data, 64'h1111);

      for (int c = 0; c < 2000; c++) begin
         int idx;
         idx      = ($urandom % 10 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
         mm_wr    = ($urandom % 4 == 0);
         mm_rd    = ($urandom % 3 == 0);
         err_clr  = ($urandom % 50 == 0);
         mm_addr  = AW'((idx << 10) | ($urandom % 1024));
         mm_wdata = {$urandom, $urandom};
         for (int i = 0; i < NT; i++) begin
            tgt_v[i] = ($urandom % 4 == 0);
            slot[i]  = {$urandom, $urandom};
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
